formula_stim_gen: RTL

Self-contained hardware stimulus source and response collector for the `formula` pipeline, for on-chip and FPGA bring-up without a simulator.
- Drives `formula` inputs `vld_in`, `a`, `b`, `c`, `d` with pseudo-random signed vectors from an LFSR.
- Consumes `vld_out` and `q`, counts results, measures pipeline latency and compresses every `q` into a MISR signature.
- Sits beside one `formula` instance; software starts a run and later reads the signature and counters.

---
 rtl/formula_stim_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/formula_stim_gen.sv
// Stimulus source and response collector for one formula pipeline instance:
// LFSR-driven operand vectors out, result count, first-result latency and MISR signature in.
module formula_stim_gen #(
  parameter int unsigned width         = 8,
  parameter int unsigned width_out     = 2 * width + 6,
  parameter logic [31:0] seed          = 32'h1,
  parameter int unsigned drain_timeout = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  num_vec,
  output logic                        vld_in,
  output logic signed [width-1:0]     a,
  output logic signed [width-1:0]     b,
  output logic signed [width-1:0]     c,
  output logic signed [width-1:0]     d,
  input  logic                        vld_out,
  input  logic signed [width_out-1:0] q,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [7:0]                  res_cnt,
  output logic [7:0]                  latency,
  output logic [width_out-1:0]        sig
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int unsigned TMO_W     = $clog2(drain_timeout + 1);
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     num_vec_q, num_vec_d;
  logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]     lat_q, lat_d;
  logic                 lat_act_q, lat_act_d;
  logic [width_out-1:0] sig_q, sig_d;
  logic                 err_q, err_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic [31:0]          lfsr_step;
  logic [TMO_W-1:0]     tmo_inc;
  logic                 busy_st;

  // One Galois step, shifting right
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign tmo_inc   = tmo_q + TMO_W'(1);
  assign busy_st   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    num_vec_d = num_vec_q;
    vec_cnt_d = vec_cnt_q;
    res_cnt_d = res_cnt_q;
    lat_d     = lat_q;
    lat_act_d = lat_act_q;
    sig_d     = sig_q;
    err_d     = err_q;
    tmo_d     = tmo_q;

    // Results arriving in IDLE can only be leftovers from before a reset and are dropped
    if (vld_out && (state_q != ST_IDLE)) begin
      tmo_d = '0;
      if (busy_st && (res_cnt_q != num_vec_q)) begin
        if (res_cnt_q != 8'hFF) begin
          res_cnt_d = res_cnt_q + CNT_W'(1);
        end
      end else begin
        err_d = 1'b1;
      end
      if (busy_st) begin
        sig_d = {sig_q[width_out-2:0], sig_q[width_out-1]} ^ $unsigned(q);
      end
    end

    // Latency runs from the first RUN cycle until the first result, saturating
    if (lat_act_q) begin
      if (vld_out) begin
        lat_act_d = 1'b0;
      end else if (lat_q != 8'hFF) begin
        lat_d = lat_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_vec_d = num_vec;
          lfsr_d    = seed;
          vec_cnt_d = '0;
          res_cnt_d = '0;
          lat_d     = '0;
          lat_act_d = (num_vec != 8'd0);
          sig_d     = '0;
          err_d     = 1'b0;
          tmo_d     = '0;
          state_d   = (num_vec != 8'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        lfsr_d    = lfsr_step;
        vec_cnt_d = vec_cnt_q + CNT_W'(1);
        if (vec_cnt_q == (num_vec_q - CNT_W'(1))) begin
          state_d = (res_cnt_d == num_vec_q) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_cnt_d == num_vec_q) begin
          state_d = ST_DONE;
        end else if (!vld_out) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_W'(drain_timeout)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= seed;
      num_vec_q <= '0;
      vec_cnt_q <= '0;
      res_cnt_q <= '0;
      lat_q     <= '0;
      lat_act_q <= 1'b0;
      sig_q     <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      num_vec_q <= num_vec_d;
      vec_cnt_q <= vec_cnt_d;
      res_cnt_q <= res_cnt_d;
      lat_q     <= lat_d;
      lat_act_q <= lat_act_d;
      sig_q     <= sig_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Outputs decode directly from flops
  assign vld_in  = (state_q == ST_RUN);
  assign busy    = busy_st;
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign res_cnt = res_cnt_q;
  assign latency = lat_q;
  assign sig     = sig_q;
  assign a       = lfsr_q[width-1:0];
  assign b       = lfsr_q[2*width-1:width];
  assign c       = lfsr_q[3*width-1:2*width];
  assign d       = lfsr_q[4*width-1:3*width];

endmodule
